// File: rtl/f_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// f_fetch_ctrl
//
// Fetch sequencer for the P7 pipeline. Owns the F-stage PC, keeps at most one
// request outstanding on a variable-latency instruction memory port, buffers
// the returned instruction for the D stage (valid/ready), and applies branch,
// eret and exception redirects.
//
// Ports
//   clk            clock
//   reset          asynchronous reset, active low
//   req            exception/interrupt flush (redirect to EXC_PC)
//   eret_i         eret flush (redirect to epc_i)
//   epc_i          eret return PC
//   br_taken_i     branch/jump resolved taken in D
//   br_target_i    branch/jump target
//   d_ready_i      D stage accepts the held slot
//   F_PC           PC of the instruction in flight or held
//   instr_o        held instruction (0 for a fetch fault)
//   instr_valid_o  instr_o / F_PC valid to D
//   exc_adel_o     held slot is an address-error fetch fault
//   imem_req_o     memory request (high exactly in ISSUE)
//   imem_addr_o    request address (always F_PC)
//   imem_gnt_i     request accepted this cycle
//   imem_rvalid_i  response valid
//   imem_rdata_i   response data
// ---------------------------------------------------------------------------
module f_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180,
    parameter logic [31:0] IMEM_LO  = 32'h0000_3000,
    parameter logic [31:0] IMEM_HI  = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        eret_i,
    input  logic [31:0] epc_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        d_ready_i,
    output logic [31:0] F_PC,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic        exc_adel_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i
);

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,   // request presented, waiting for grant
        ST_WAIT  = 2'd1,   // granted, waiting for response
        ST_HOLD  = 2'd2,   // slot buffered and shown to D
        ST_DRAIN = 2'd3    // killed request still owes a response
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] instr_reg;
    logic        valid_reg;
    logic        adel_reg;
    logic        br_pend_reg;
    logic [31:0] br_tgt_reg;
    logic [31:0] flush_tgt_reg;

    logic        flush;
    logic [31:0] flush_pc;
    logic        handshake;
    logic [31:0] seq_pc;
    logic        redir;
    logic [31:0] redir_pc;
    logic        redir_legal;

    function automatic logic pc_legal(input logic [31:0] pc);
        return (pc[1:0] == 2'b00) && (pc >= IMEM_LO) && (pc <= IMEM_HI);
    endfunction

    assign flush     = req | eret_i;
    assign flush_pc  = req ? EXC_PC : epc_i;
    assign handshake = valid_reg & d_ready_i;
    // F_PC + 4 wraps modulo 2^32; the range check then turns it into a fault.
    assign seq_pc    = br_pend_reg ? br_tgt_reg : (pc_reg + 32'd4);

    // Decide whether the controller moves to a new PC this cycle, and which.
    // A redirect always lands in ISSUE (legal PC) or a faulting HOLD slot.
    always_comb begin
        redir    = 1'b0;
        redir_pc = pc_reg;
        case (state_reg)
            ST_ISSUE: begin
                // Without a grant nothing was accepted, so the request can
                // simply be withdrawn. With a grant the memory owes data.
                if (flush && !imem_gnt_i) begin
                    redir    = 1'b1;
                    redir_pc = flush_pc;
                end
            end
            ST_WAIT: begin
                // Response arriving together with the flush is just dropped.
                if (flush && imem_rvalid_i) begin
                    redir    = 1'b1;
                    redir_pc = flush_pc;
                end
            end
            ST_HOLD: begin
                // Flush beats a same-cycle handshake.
                if (flush) begin
                    redir    = 1'b1;
                    redir_pc = flush_pc;
                end else if (handshake) begin
                    redir    = 1'b1;
                    redir_pc = seq_pc;
                end
            end
            ST_DRAIN: begin
                // A flush landing on the same cycle as the stale response
                // wins over the older stored target.
                if (imem_rvalid_i) begin
                    redir    = 1'b1;
                    redir_pc = flush ? flush_pc : flush_tgt_reg;
                end
            end
            default: begin
                redir    = 1'b0;
                redir_pc = pc_reg;
            end
        endcase
    end

    assign redir_legal = pc_legal(redir_pc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_ISSUE;
            pc_reg        <= RESET_PC;
            instr_reg     <= 32'd0;
            valid_reg     <= 1'b0;
            adel_reg      <= 1'b0;
            br_pend_reg   <= 1'b0;
            br_tgt_reg    <= 32'd0;
            flush_tgt_reg <= 32'd0;
        end else begin
            // Pending-branch bookkeeping. A branch resolved in the same cycle
            // as a handshake belongs to the next slot, so it re-arms br_pend
            // after the handshake has consumed the previous one.
            if (flush) begin
                br_pend_reg   <= 1'b0;
                flush_tgt_reg <= flush_pc;
            end else if (br_taken_i) begin
                br_pend_reg <= 1'b1;
                br_tgt_reg  <= br_target_i;
            end else if (handshake) begin
                br_pend_reg <= 1'b0;
            end

            if (redir) begin
                pc_reg <= redir_pc;
                if (redir_legal) begin
                    state_reg <= ST_ISSUE;
                    valid_reg <= 1'b0;
                    adel_reg  <= 1'b0;
                end else begin
                    // Illegal PC: never reaches the bus, shown as a nop fault.
                    state_reg <= ST_HOLD;
                    instr_reg <= 32'd0;
                    valid_reg <= 1'b1;
                    adel_reg  <= 1'b1;
                end
            end else begin
                case (state_reg)
                    ST_ISSUE: begin
                        if (imem_gnt_i) begin
                            state_reg <= flush ? ST_DRAIN : ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (flush) begin
                            state_reg <= ST_DRAIN;
                        end else if (imem_rvalid_i) begin
                            state_reg <= ST_HOLD;
                            instr_reg <= imem_rdata_i;
                            valid_reg <= 1'b1;
                            adel_reg  <= 1'b0;
                        end
                    end
                    default: begin
                        // HOLD and DRAIN only leave via a redirect.
                        state_reg <= state_reg;
                    end
                endcase
            end
        end
    end

    assign F_PC          = pc_reg;
    assign instr_o       = instr_reg;
    assign instr_valid_o = valid_reg;
    assign exc_adel_o    = adel_reg;
    assign imem_req_o    = (state_reg == ST_ISSUE);
    assign imem_addr_o   = pc_reg;

endmodule

// File: tb/tb_f_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_f_fetch_ctrl
//
// Randomized bench for f_fetch_ctrl. A bus-side memory model answers granted
// requests after a random delay; the reference model tracks the stream of
// instruction slots D must see (PC order, pending branch, flush targets) and
// checks every accepted slot, every request address, and the reset/latency
// behaviour right after each reset release.
// ---------------------------------------------------------------------------
module tb_f_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC   = 32'h0000_4180;
    localparam int          NCYC     = 6000;
    localparam int          STALL_MAX = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        eret_i;
    logic [31:0] epc_i;
    logic        br_taken_i;
    logic [31:0] br_target_i;
    logic        d_ready_i;
    logic [31:0] F_PC;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic        exc_adel_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;

    f_fetch_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .eret_i        (eret_i),
        .epc_i         (epc_i),
        .br_taken_i    (br_taken_i),
        .br_target_i   (br_target_i),
        .d_ready_i     (d_ready_i),
        .F_PC          (F_PC),
        .instr_o       (instr_o),
        .instr_valid_o (instr_valid_o),
        .exc_adel_o    (exc_adel_o),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: PC of the next slot D must receive.
    logic [31:0] exp_pc;
    bit          bp;
    logic [31:0] bt;
    bit          prev_flush;
    logic [31:0] prev_tgt;
    int          rel;
    int          idle;
    int          txn;

    // Memory model state.
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= 32'h0000_3000) && (a <= 32'h0000_6FFC);
    endfunction

    // Distinct contents per address so a stale or misrouted word is visible.
    function automatic logic [31:0] memval(input logic [31:0] a);
        return (a ^ 32'h5A5A_0000) * 32'h9E37_79B1;
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] a;
        case ($urandom_range(0, 7))
            0, 1, 2, 3: a = 32'h3000 + ($urandom_range(0, 32'hFFF) << 2);
            4:          a = 32'h6FF0 + ($urandom_range(0, 3) << 2);
            5:          a = 32'h3000 + ($urandom_range(0, 32'hFFF) << 2) + $urandom_range(1, 3);
            6:          a = ($urandom_range(0, 1) != 0) ? 32'h0000_2FFC : 32'hFFFF_FFFC;
            default:    a = $urandom();
        endcase
        return a;
    endfunction

    task automatic do_reset();
        reset         = 1'b0;
        req           = 1'b0;
        eret_i        = 1'b0;
        epc_i         = 32'd0;
        br_taken_i    = 1'b0;
        br_target_i   = 32'd0;
        d_ready_i     = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_F_PC", F_PC, RESET_PC);
        check("rst_instr", instr_o, 32'd0);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_adel", 32'(exc_adel_o), 32'd0);
        check("rst_req", 32'(imem_req_o), 32'd1);
        check("rst_addr", imem_addr_o, RESET_PC);
        @(posedge clk);
        #1;
        reset      = 1'b1;
        exp_pc     = RESET_PC;
        bp         = 1'b0;
        bt         = 32'd0;
        prev_flush = 1'b0;
        prev_tgt   = 32'd0;
        rel        = 0;
        idle       = 0;
        mem_busy   = 1'b0;
        mem_cnt    = 0;
        mem_addr   = 32'd0;
    endtask

    // Inputs for the current cycle; the first cycles after reset use an
    // always-granting, minimum-latency memory and a ready D stage.
    task automatic drive_inputs();
        if (rel < 6) begin
            imem_gnt_i = imem_req_o;
            d_ready_i  = 1'b1;
            req        = 1'b0;
            eret_i     = 1'b0;
            br_taken_i = 1'b0;
        end else begin
            imem_gnt_i = imem_req_o && ($urandom_range(0, 2) != 0);
            d_ready_i  = ($urandom_range(0, 3) != 0);
            req        = ($urandom_range(0, 39) == 0);
            eret_i     = ($urandom_range(0, 29) == 0);
            br_taken_i = ($urandom_range(0, 9) == 0);
        end
        epc_i         = rand_pc();
        br_target_i   = rand_pc();
        imem_rvalid_i = mem_busy && (mem_cnt == 0);
        imem_rdata_i  = imem_rvalid_i ? memval(mem_addr) : $urandom();
    endtask

    task automatic observe();
        bit          flush;
        logic [31:0] ftgt;
        logic [31:0] exp_instr;
        bit          hs;
        flush = req || eret_i;
        ftgt  = req ? EXC_PC : epc_i;
        hs    = instr_valid_o && d_ready_i && !flush;

        if (rel < 6) begin
            check("lat_valid", 32'(instr_valid_o), 32'((rel == 2) || (rel == 5)));
        end
        if (rel == 0) begin
            check("first_req", 32'(imem_req_o), 32'd1);
            check("first_addr", imem_addr_o, RESET_PC);
        end
        if (prev_flush && legal(prev_tgt)) begin
            check("valid_after_flush", 32'(instr_valid_o), 32'd0);
        end
        if (imem_req_o) begin
            check("req_addr", imem_addr_o, exp_pc);
        end
        if (!legal(exp_pc)) begin
            check("no_req_illegal", 32'(imem_req_o), 32'd0);
        end

        if (hs) begin
            exp_instr = legal(exp_pc) ? memval(exp_pc) : 32'd0;
            check("slot_pc", F_PC, exp_pc);
            check("slot_instr", instr_o, exp_instr);
            check("slot_adel", 32'(exc_adel_o), 32'(!legal(exp_pc)));
            txn++;
            $display("txn %0d pc=%h instr=%h adel=%0d", txn, F_PC, instr_o, exc_adel_o);
        end

        // Slot-stream model update for this cycle's events.
        if (flush) begin
            exp_pc = ftgt;
            bp     = 1'b0;
        end else begin
            if (hs) begin
                exp_pc = bp ? bt : exp_pc + 32'd4;
                bp     = 1'b0;
            end
            if (br_taken_i) begin
                bp = 1'b1;
                bt = br_target_i;
            end
        end
        idle = (hs || flush) ? 0 : idle + 1;

        // Memory model: one outstanding access, response 1..4 cycles after grant.
        if (imem_rvalid_i) mem_busy = 1'b0;
        if (imem_req_o && imem_gnt_i) begin
            mem_busy = 1'b1;
            mem_addr = imem_addr_o;
            mem_cnt  = (rel < 6) ? 0 : int'($urandom_range(0, 3));
        end else if (mem_busy && mem_cnt > 0) begin
            mem_cnt--;
        end

        prev_flush = flush;
        prev_tgt   = ftgt;
        rel++;
    endtask

    initial begin
        txn = 0;
        do_reset();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            if (cyc == NCYC / 2) do_reset();
            drive_inputs();
            @(negedge clk);
            observe();
            if (idle > STALL_MAX) begin
                check("stall_cycles", 32'(idle), 32'd0);
                break;
            end
            @(posedge clk);
            #1;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
